uart_word_streamer: RTL
=======================

Name: uart_word_streamer

Overview:
- Synthesizable, parametrised UART serializer that drives the `rx` pin of `rv_uart_top` (or any UART receiver) from a queue of words.
- Each word is unpacked least-significant byte first and framed as 8N1, with optional parity and a configurable number of stop bits.
- A per-word byte mode sends only the low byte.
- Used as an on-chip or bench program loader; it replaces hand bit-banging of the `rx` line.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per serial bit (>=2).
- WORD_BYTES, 4, bytes per queued word (1..8).
- FIFO_DEPTH, 8, word queue entries (power of two, >=2).
- PARITY_EN, 0, 1 = append a parity bit after the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored when PARITY_EN=0).
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  in  1  system clock.
- Rst  in  1  asynchronous reset, active-low (Rst=0 resets).
- word_in  in  8*WORD_BYTES  word to send; byte 0 = bits [7:0].
- byte_mode  in  1  sampled with word_in; 1 = send only word_in[7:0].
- word_valid  in  1  push request.
- word_ready  out  1  queue not full; push accepted on rising clk when word_valid && word_ready.
- abort  in  1  synchronous flush of queue and current frame.
- tx  out  1  serial line to the receiver `rx`; idle high.
- busy  out  1  frame in progress or queue non-empty.
- word_done  out  1  one-cycle pulse when the stop bit(s) of a word's last byte finish.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied queue entries.

Behaviour:
- Reset values (Rst=0, asynchronous): tx=1, busy=0, word_done=0, fifo_count=0, word_ready=1, state=IDLE, all counters 0, queue empty.
- Queue:
  - FIFO of {byte_mode, word_in}; word_ready = (fifo_count != FIFO_DEPTH).
  - A push while full is ignored; no overwrite.
  - Simultaneous push and pop: fifo_count unchanged, both take effect.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states and transitions:
  - IDLE: tx=1. If the queue is non-empty at a rising edge, pop the head into the shift register. byte_idx=0, last_idx = byte_mode ? 0 : WORD_BYTES-1. Go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit_idx=0.
  - DATA: tx = current byte, LSB first. Each bit is held CLKS_PER_BIT cycles. After bit 7, go to PARITY if PARITY_EN, else STOP.
  - PARITY: tx = XOR of the 8 data bits, XOR PARITY_ODD, for CLKS_PER_BIT cycles, then STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. Then:
    - if byte_idx<last_idx: byte_idx+1, shift to the next byte, go to START with no idle gap;
    - else: word_done=1 for that one cycle, go to IDLE.
- Timing:
  - tx is registered and changes on the same edge as the state change.
  - Frame length = CLKS_PER_BIT*(1+8+PARITY_EN+STOP_BITS) cycles.
  - Minimum inter-word gap = 1 cycle (the IDLE pop cycle).
  - Latency from push into an empty idle queue to tx falling = 2 edges (push edge, pop edge).
- Baud counter: counts 0..CLKS_PER_BIT-1 and reloads 0 at every bit boundary. Its width is $clog2(CLKS_PER_BIT).
- busy = (state != IDLE) || (fifo_count != 0).
- abort (synchronous, highest priority over push and pop):
  - next edge gives state=IDLE, tx=1, queue emptied, fifo_count=0, no word_done pulse.
  - A push in the same cycle is dropped.
  - A partial frame is truncated; the receiver sees a framing error, which is acceptable.
- Reset mid-frame: tx returns high asynchronously; all state is lost.
- byte_mode word: exactly one frame containing word_in[7:0]; the upper bytes are never transmitted.

Test Plan (CLKS_PER_BIT=4, WORD_BYTES=4, FIFO_DEPTH=4 unless noted):
- Push 0xDEADBEEF, byte_mode=0 -> tx carries frames EF, BE, AD, DE back-to-back, each 40 cycles (start 4 + data 32 + stop 4).
  - First falling edge 2 edges after the push.
  - word_done pulses once, 160 cycles after the first falling edge.
  - busy=0 after.
- Push 0x000000A5, byte_mode=1 -> a single frame with bits 1,0,1,0,0,1,0,1 then stop. word_done after 40 cycles.
- Push 5 words with the FIFO drained 0 -> word_ready falls when fifo_count=4 and the 5th push is ignored. Pushes stay blocked until the first pop, after which word_ready=1, fifo_count=3.
- PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2, byte_mode push of 0x07 -> parity bit=1, stop high for 8 cycles, frame 48 cycles. With PARITY_ODD=1 -> parity bit=0.
- abort asserted mid DATA of byte 1 with 2 words queued -> next edge tx=1, fifo_count=0, busy=0, no word_done.
- Rst=0 pulsed mid-frame (asynchronous, between clk edges) -> tx=1 and fifo_count=0 immediately. After release, a new push transmits normally.

Source files
------------

// File: rtl/uart_word_streamer.sv
// uart_word_streamer: queues words and serialises them least-significant
// byte first onto a UART line (start, 8 data bits LSB first, optional
// parity, 1 or 2 stop bits). A per-word byte mode sends only the low byte.
module uart_word_streamer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int WORD_BYTES   = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clk,
  input  logic                          Rst,
  input  logic [8*WORD_BYTES-1:0]       word_in,
  input  logic                          byte_mode,
  input  logic                          word_valid,
  output logic                          word_ready,
  input  logic                          abort,
  output logic                          tx,
  output logic                          busy,
  output logic                          word_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BIDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int DATA_W = 8 * WORD_BYTES;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [BIDX_W-1:0] BYTE_LAST = BIDX_W'(WORD_BYTES - 1);
  localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic              PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------- queue
  logic [DATA_W:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W:0]   w_head;

  assign word_ready = (r_count != FULL_CNT);
  assign w_push     = word_valid && word_ready && !abort;
  assign w_head     = r_mem[r_rd_ptr];

  // Queue storage: entries are {byte_mode, word_in}, no reset needed
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {byte_mode, word_in};
  end

  // Queue pointers and occupancy; abort empties the queue
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (abort) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------- framer
  state_t             r_state, w_state_nxt;
  logic               r_tx, w_tx_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [2:0]         r_bit, w_bit_nxt;
  logic [BIDX_W-1:0]  r_byte, w_byte_nxt;
  logic [BIDX_W-1:0]  r_last, w_last_nxt;
  logic [DATA_W-1:0]  r_shift, w_shift_nxt;
  logic               r_done, w_done_nxt;
  logic               w_cnt_end;
  logic [2:0]         w_bit_inc;

  assign w_cnt_end = (r_cnt == CNT_LAST);
  assign w_bit_inc = r_bit + 3'd1;

  // Framer registers; tx is registered so it moves with the state
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= S_IDLE;
      r_tx    <= 1'b1;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_last  <= '0;
      r_shift <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tx    <= w_tx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_byte  <= w_byte_nxt;
      r_last  <= w_last_nxt;
      r_shift <= w_shift_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state and next-output logic; r_bit doubles as the stop-bit counter
  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = r_tx;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_byte_nxt  = r_byte;
    w_last_nxt  = r_last;
    w_shift_nxt = r_shift;
    w_done_nxt  = 1'b0;
    w_pop       = 1'b0;

    if (abort) begin
      w_state_nxt = S_IDLE;
      w_tx_nxt    = 1'b1;
      w_cnt_nxt   = '0;
      w_bit_nxt   = '0;
      w_byte_nxt  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_tx_nxt = 1'b1;
          if (r_count != '0) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head[DATA_W-1:0];
            w_byte_nxt  = '0;
            w_last_nxt  = w_head[DATA_W] ? '0 : BYTE_LAST;
            w_cnt_nxt   = '0;
            w_bit_nxt   = '0;
            w_tx_nxt    = 1'b0;
            w_state_nxt = S_START;
          end
        end
        S_START: begin
          if (w_cnt_end) begin
            w_cnt_nxt   = '0;
            w_bit_nxt   = '0;
            w_tx_nxt    = r_shift[0];
            w_state_nxt = S_DATA;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (w_cnt_end) begin
            w_cnt_nxt = '0;
            if (r_bit == 3'd7) begin
              w_bit_nxt = '0;
              if (PARITY_EN != 0) begin
                w_tx_nxt    = (^r_shift[7:0]) ^ PAR_ODD;
                w_state_nxt = S_PARITY;
              end else begin
                w_tx_nxt    = 1'b1;
                w_state_nxt = S_STOP;
              end
            end else begin
              w_bit_nxt = w_bit_inc;
              w_tx_nxt  = r_shift[w_bit_inc];
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        S_PARITY: begin
          if (w_cnt_end) begin
            w_cnt_nxt   = '0;
            w_bit_nxt   = '0;
            w_tx_nxt    = 1'b1;
            w_state_nxt = S_STOP;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (w_cnt_end) begin
            w_cnt_nxt = '0;
            if (r_bit == STOP_LAST) begin
              w_bit_nxt = '0;
              if (r_byte < r_last) begin
                w_byte_nxt  = r_byte + BIDX_W'(1);
                w_shift_nxt = r_shift >> 8;
                w_tx_nxt    = 1'b0;
                w_state_nxt = S_START;
              end else begin
                w_tx_nxt    = 1'b1;
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
              end
            end else begin
              w_bit_nxt = w_bit_inc;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_tx_nxt    = 1'b1;
        end
      endcase
    end
  end

  assign tx         = r_tx;
  assign word_done  = r_done;
  assign fifo_count = r_count;
  assign busy       = (r_state != S_IDLE) || (r_count != '0);

endmodule
